// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a registered result that stays in DONE until it is consumed.
// ALU_PIPE_MUL_EN adds a WIDTH-cycle shift-add multiplier for op 110; without it op 110 reports err.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
  logic [4:0] flags_q, flags_d;
  logic [WIDTH:0] add_w, sub_w;
  logic [WIDTH-1:0] alu_r;
  logic alu_c, alu_v, accept;
  assign accept = (state_q == IDLE) && in_valid;
  always_comb begin
    add_w = {1'b0, a} + {1'b0, b};
    sub_w = {1'b0, a} - {1'b0, b};
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      3'b000: begin
        alu_r = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        alu_r = sub_w[WIDTH-1:0];
        alu_c = sub_w[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: alu_r = a & b;
      3'b011: alu_r = a | b;
      3'b100: alu_r = a ^ b;
      3'b101: alu_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      3'b111: alu_r = ~a;
      default: alu_r = '0;
    endcase
  end
`ifdef ALU_PIPE_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] psum;
  // Product high half accumulates the multiplicand; the low half starts as b and shifts out.
  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    psum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, prod_q[0] ? mcand_q : {WIDTH{1'b0}}};
    if (accept && op == 3'b110) begin
      mcand_d = a;
      prod_d  = {{WIDTH{1'b0}}, b};
      cnt_d   = '0;
    end else if (state_q == BUSY) begin
      prod_d = {psum, prod_q[WIDTH-1:1]};
      cnt_d  = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
`endif
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    hi_d    = hi_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (op == 3'b110) begin
`ifdef ALU_PIPE_MUL_EN
          state_d = BUSY;
`else
          state_d = DONE;
          res_d   = '0;
          hi_d    = '0;
          flags_d = 5'b00001;
`endif
        end else begin
          state_d = DONE;
          res_d   = alu_r;
          hi_d    = '0;
          flags_d = {alu_c, ~|alu_r, alu_r[WIDTH-1], alu_v, 1'b0};
        end
      end
`ifdef ALU_PIPE_MUL_EN
      BUSY: if (cnt_q == LAST) begin
        state_d = DONE;
        res_d   = prod_d[WIDTH-1:0];
        hi_d    = prod_d[2*WIDTH-1:WIDTH];
        flags_d = {|prod_d[2*WIDTH-1:WIDTH], ~|prod_d, prod_d[2*WIDTH-1], 2'b00};
      end
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
    end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result    = res_q;
  assign result_hi = hi_q;
  assign {carry, zero, neg, ovf, err} = flags_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed scoreboard bench for alu_pipe at WIDTH=8 (either ALU_PIPE_MUL_EN build).
module tb_alu_pipe;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic [2:0] op = '0;
  logic in_ready, out_valid, carry, zero, neg, ovf, err;
  logic [7:0] result, result_hi;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] h;
    logic [4:0] f;
    int lat;
  } exp_t;
  exp_t sb[$];

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .carry(carry), .zero(zero),
    .neg(neg), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0 ] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model in plain integer arithmetic; flags packed {carry,zero,neg,ovf,err}.
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
    exp_t e;
    int sx = $signed(x);
    int sy = $signed(y);
    int t;
    logic [15:0] p;
    logic c, v;
    e = '0;
    e.lat = 1;
    c = 1'b0;
    v = 1'b0;
    p = 16'(x) * 16'(y);
    case (o)
      3'd0: begin t = sx + sy; e.r = x + y; c = (int'(x) + int'(y)) > 255; v = (t > 127) || (t < -128); end
      3'd1: begin t = sx - sy; e.r = x - y; c = x < y; v = (t > 127) || (t < -128); end
      3'd2: e.r = x & y;
      3'd3: e.r = x | y;
      3'd4: e.r = x ^ y;
      3'd5: e.r = (sx < sy) ? 8'd1 : 8'd0;
      3'd7: e.r = ~x;
      default: e.r = '0;
    endcase
    if (o != 3'd6) e.f = {c, e.r == 8'd0, e.r[7], v, 1'b0};
    else begin
`ifdef ALU_PIPE_MUL_EN
      e.r = p[7:0];
      e.h = p[15:8];
      e.f = {p[15:8] != 8'd0, p == 16'd0, p[15], 2'b00};
      e.lat = 9;
`else
      e.f = 5'b00001;
`endif
    end
    return e;
  endfunction

  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top);
    exp_t e;
    int lat;
    sb.push_back(model(ta, tb, top));
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a = ta; b = tb; op = top; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check("latency", lat, e.lat);
    check("result", result, e.r);
    check("result_hi", result_hi, e.h);
    check("flags", {carry, zero, neg, ovf, err}, e.f);
    check("in_ready_done", in_ready, 0);
  endtask

  logic [7:0] va [14] = '{8'hF0, 8'h05, 8'h80, 8'h0F, 8'hA0, 8'hFF, 8'h80, 8'h01, 8'h5A, 8'h7F, 8'h00, 8'hFF, 8'h00, 8'h0F};
  logic [7:0] vb [14] = '{8'h20, 8'h07, 8'h01, 8'h3C, 8'h05, 8'hFF, 8'h01, 8'h80, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h37, 8'h0F};
  logic [2:0] vo [14] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd7, 3'd0, 3'd0, 3'd6, 3'd6, 3'd6};

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", {result_hi, result}, 0);
    check("rst_flags", {carry, zero, neg, ovf, err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    for (int i = 0; i < 14; i++) send(va[i], vb[i], vo[i]);
    @(negedge clk);
    check("handoff_idle", out_valid, 0);
    out_ready = 1'b0;
    send(8'h0F, 8'h3C, 3'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 8'h01; b = 8'h01; op = 3'd0; in_valid = 1'b1;
      check("bp_valid", out_valid, 1);
      check("bp_result", result, 8'h0C);
      check("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_released", out_valid, 0);
    check("bp_ready_back", in_ready, 1);
    @(negedge clk);
    check("bp_no_second", out_valid, 0);
    a = 8'hFF; b = 8'hFF; op = 3'd6; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_result", {result_hi, result}, 0);
    check("abort_flags", {carry, zero, neg, ovf, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_deliver", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    send(8'h01, 8'h01, 3'd0);
    check("after_abort_add", result, 8'h02);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
